// File: rtl/uart_pkg.sv
// Shared UART timebase types and default parameters.
// Imported by the tick counter and the baud controller.
package uart_pkg;

  localparam int DEF_CNT_W      = 26;
  localparam int DEF_DIV        = 49;
  localparam int DEF_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } state_e;

endpackage

// File: rtl/uart_tick_counter.sv
// Prescale counter plus oversample counter for the UART timebase.
// Emits combinational wrap strobes; the caller registers the ticks.
module uart_tick_counter
  import uart_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             load_div_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             os_wrap_o,
  output logic             baud_wrap_o
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] q_q, q_d;
  logic [OS_W-1:0]  os_q, os_d;

  assign os_wrap_o   = (q_q == div_i);
  assign baud_wrap_o = os_wrap_o && (os_q == OS_LAST);

  always_comb begin
    q_d  = q_q + CNT_W'(1);
    os_d = os_q;
    if (clear_i || load_div_i) begin
      q_d  = '0;
      os_d = '0;
    end else if (os_wrap_o) begin
      q_d  = '0;
      os_d = baud_wrap_o ? '0 : os_q + OS_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      q_q  <= '0;
      os_q <= '0;
    end else begin
      q_q  <= q_d;
      os_q <= os_d;
    end
  end

endmodule

// File: rtl/uart_baud_controller.sv
// UART timebase: programmable 16x oversample tick and 1x baud tick.
// Divisor updates are deferred to a baud boundary while running.
module uart_baud_controller
  import uart_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV,
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [CNT_W-1:0] cur_div,
  output logic             os_tick,
  output logic             baud_tick,
  output logic             pending
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] held_q, held_d;
  logic             os_tick_q, baud_tick_q, err_q;

  logic running, boundary, accept, legal;
  logic os_wrap, baud_wrap;

  assign running  = enable && (state_q != IDLE);
  assign boundary = running && (state_q == PEND) && baud_wrap;
  assign accept   = cfg_valid && cfg_ready;
  assign legal    = accept && (cfg_div != '0);

  uart_tick_counter #(
    .CNT_W      (CNT_W),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_cnt (
    .clk_in      (clk_in),
    .rst         (rst),
    .clear_i     (!running),
    .load_div_i  (boundary),
    .div_i       (cur_div_q),
    .os_wrap_o   (os_wrap),
    .baud_wrap_o (baud_wrap)
  );

  always_comb begin
    state_d   = state_q;
    cur_div_d = cur_div_q;
    held_d    = held_q;
    if (!enable) begin
      // Halting flushes any deferred divisor straight into effect
      state_d = IDLE;
      if (state_q == PEND) begin
        cur_div_d = held_q;
      end else if (legal) begin
        cur_div_d = cfg_div;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = RUN;
          if (legal) cur_div_d = cfg_div;
        end
        RUN: begin
          if (legal) begin
            held_d  = cfg_div;
            state_d = PEND;
          end
        end
        PEND: begin
          if (boundary) begin
            cur_div_d = held_q;
            state_d   = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_div_q   <= CNT_W'(DEFAULT_DIV);
      held_q      <= '0;
      os_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_div_q   <= cur_div_d;
      held_q      <= held_d;
      os_tick_q   <= running && os_wrap;
      baud_tick_q <= running && baud_wrap;
      err_q       <= accept && (cfg_div == '0);
    end
  end

  assign cfg_ready = (state_q != PEND);
  assign pending   = (state_q == PEND);
  assign cfg_err   = err_q;
  assign cur_div   = cur_div_q;
  assign os_tick   = os_tick_q;
  assign baud_tick = baud_tick_q;

endmodule
